// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: queues ALU commands, drives each onto the
// combinational ALU, waits a settle time, samples and returns results.
// Ports:
//   cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op : command input handshake
//   alu_a/alu_b/alu_op -> ALU inputs, alu_result/alu_cout <- ALU outputs
//   res_valid/res_ready/res_data/res_cout/res_op : result handshake
//   cmd_count : FIFO occupancy, busy : work queued or in flight
module alu_issue_sequencer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [7:0]                    cmd_a,
  input  logic [7:0]                    cmd_b,
  input  logic [2:0]                    cmd_op,
  output logic [7:0]                    alu_a,
  output logic [7:0]                    alu_b,
  output logic [2:0]                    alu_op,
  input  logic [15:0]                   alu_result,
  input  logic                          alu_cout,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [15:0]                   res_data,
  output logic                          res_cout,
  output logic [2:0]                    res_op,
  output logic [$clog2(FIFO_DEPTH):0]   cmd_count,
  output logic                          busy
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int SW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    HOLD
  } state_t;

  state_t state, nextState;

  cmd_t            mem [FIFO_DEPTH];
  cmd_t            head;
  logic [PW-1:0]   wrPtr, rdPtr;
  logic [CNTW-1:0] count;
  logic            full, empty;
  logic            push, pop;
  logic            capture;
  logic [SW-1:0]   settleCnt;

  assign full      = (count == CNTW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rdPtr];
  assign cmd_count = count;
  assign busy      = (state != IDLE) || !empty;

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
    end
  end

  // Pointers wrap for free because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    pop       = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          nextState = DRIVE;
        end
      end
      DRIVE: begin
        if (settleCnt == '0) begin
          capture   = 1'b1;
          nextState = HOLD;
        end
      end
      HOLD: begin
        // Chain straight into the next command on the same edge.
        if (res_ready) begin
          pop       = !empty;
          nextState = empty ? IDLE : DRIVE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      settleCnt <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cout  <= 1'b0;
      res_op    <= '0;
    end else begin
      if (pop) begin
        alu_a     <= head.a;
        alu_b     <= head.b;
        alu_op    <= head.op;
        settleCnt <= SETTLE_INIT;
      end else if (state == DRIVE && settleCnt != '0) begin
        settleCnt <= settleCnt - 1'b1;
      end
      if (capture) begin
        res_data  <= alu_result;
        res_cout  <= alu_cout;
        res_op    <= alu_op;
        res_valid <= 1'b1;
      end else if (state == HOLD && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb_alu_issue_sequencer: directed bench for alu_issue_sequencer
// with an adder standing in for the ALU.
module tb_alu_issue_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic [7:0]  cmdA = '0;
  logic [7:0]  cmdB = '0;
  logic [2:0]  cmdOp = '0;
  logic [7:0]  aluA, aluB;
  logic [2:0]  aluOp;
  logic [15:0] aluResult;
  logic        aluCout;
  logic        resValid;
  logic        resReady = 1'b0;
  logic [15:0] resData;
  logic        resCout;
  logic [2:0]  resOp;
  logic [2:0]  cmdCount;
  logic        busy;
  logic [8:0]  aluSum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign aluSum    = {1'b0, aluA} + {1'b0, aluB};
  assign aluResult = {7'b0, aluSum};
  assign aluCout   = aluSum[8];

  alu_issue_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmdValid), .cmd_ready(cmdReady),
    .cmd_a(cmdA), .cmd_b(cmdB), .cmd_op(cmdOp),
    .alu_a(aluA), .alu_b(aluB), .alu_op(aluOp),
    .alu_result(aluResult), .alu_cout(aluCout),
    .res_valid(resValid), .res_ready(resReady),
    .res_data(resData), .res_cout(resCout), .res_op(resOp),
    .cmd_count(cmdCount), .busy(busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    int idx;
    int n;

    // 1: asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 16'(resValid), 16'd0);
    chk("rst_count", 16'(cmdCount), 16'd0);
    chk("rst_alu_a", 16'(aluA), 16'd0);
    chk("rst_alu_b", 16'(aluB), 16'd0);
    chk("rst_ready", 16'(cmdReady), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // 2: single command, latency and one-cycle valid
    @(negedge clk);
    cmdA = 8'h02; cmdB = 8'h0A; cmdOp = 3'd0;
    cmdValid = 1'b1; resReady = 1'b1;
    chk("t2_ready", 16'(cmdReady), 16'd1);
    @(posedge clk);
    #1 cmdValid = 1'b0;
    @(negedge clk);
    chk("t2_lat0", 16'(resValid), 16'd0);
    @(negedge clk);
    chk("t2_lat1", 16'(resValid), 16'd0);
    @(negedge clk);
    chk("t2_lat2", 16'(resValid), 16'd1);
    chk("t2_data", resData, 16'h000C);
    chk("t2_cout", 16'(resCout), 16'd0);
    chk("t2_op", 16'(resOp), 16'd0);
    @(negedge clk);
    chk("t2_drop", 16'(resValid), 16'd0);
    chk("t2_idle", 16'(busy), 16'd0);

    // 3: carry out
    cmdA = 8'hF6; cmdB = 8'h0A; cmdOp = 3'd3; cmdValid = 1'b1;
    @(posedge clk);
    #1 cmdValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t3_valid", 16'(resValid), 16'd1);
    chk("t3_data", resData, 16'h0100);
    chk("t3_cout", 16'(resCout), 16'd1);
    chk("t3_op", 16'(resOp), 16'd3);
    @(negedge clk);

    // 4: backpressure fills the FIFO
    resReady = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      cmdA = 8'(idx); cmdB = 8'h10; cmdOp = 3'(idx);
      cmdValid = 1'b1;
      if (cmdReady && idx < 5) idx++;
    end
    chk("t4_ready", 16'(cmdReady), 16'd0);
    cmdValid = 1'b0;
    chk("t4_accepted", 16'(idx), 16'd5);
    chk("t4_count", 16'(cmdCount), 16'd4);
    chk("t4_hold", 16'(resValid), 16'd1);
    chk("t4_data0", resData, 16'h0010);
    chk("t4_op0", 16'(resOp), 16'd0);
    resReady = 1'b1;
    for (int k = 1; k < 5; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!resValid && n < 10);
      chk("t4_gap", 16'(n), 16'd2);
      chk("t4_data", resData, 16'(16'h0010 + k));
      chk("t4_op", 16'(resOp), 16'(k));
    end
    @(negedge clk);
    chk("t4_empty_valid", 16'(resValid), 16'd0);
    chk("t4_empty_count", 16'(cmdCount), 16'd0);
    chk("t4_reopen", 16'(cmdReady), 16'd1);
    cmdA = 8'd5; cmdB = 8'h10; cmdOp = 3'd5; cmdValid = 1'b1;
    @(posedge clk);
    #1 cmdValid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resValid && n < 10);
    chk("t4_sixth_valid", 16'(resValid), 16'd1);
    chk("t4_sixth_data", resData, 16'h0015);
    chk("t4_sixth_op", 16'(resOp), 16'd5);
    @(negedge clk);

    // 5: reset mid-operation
    resReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      cmdA = 8'(8'h20 + i); cmdB = 8'h01; cmdOp = 3'(i);
      cmdValid = 1'b1;
    end
    @(negedge clk);
    cmdValid = 1'b0;
    chk("t5_pre_valid", 16'(resValid), 16'd1);
    chk("t5_pre_count", 16'(cmdCount), 16'd3);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", 16'(resValid), 16'd0);
    chk("t5_rst_count", 16'(cmdCount), 16'd0);
    chk("t5_rst_ready", 16'(cmdReady), 16'd1);
    @(negedge clk);
    rst = 1'b0;
    resReady = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5_quiet_valid", 16'(resValid), 16'd0);
    chk("t5_quiet_busy", 16'(busy), 16'd0);

    // 6: opcode sweep, producer and consumer concurrently
    fork
      begin
        int w;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          cmdA = 8'h02; cmdB = 8'h0A; cmdOp = 3'(i);
          cmdValid = 1'b1;
          w = 0;
          while (!cmdReady && w < 50) begin
            @(negedge clk);
            w++;
          end
        end
        @(negedge clk);
        cmdValid = 1'b0;
      end
      begin
        int m;
        for (int k = 0; k < 8; k++) begin
          m = 0;
          while (!resValid && m < 20) begin
            @(negedge clk);
            m++;
          end
          chk("t6_valid", 16'(resValid), 16'd1);
          chk("t6_res_op", 16'(resOp), 16'(k));
          chk("t6_alu_op", 16'(aluOp), 16'(k));
          chk("t6_data", resData, 16'h000C);
          @(negedge clk);
        end
      end
    join
    repeat (2) @(negedge clk);
    chk("t6_done", 16'(busy), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
